// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: commits MEM/WB results,
// serves two bypassed read ports and tracks in-flight destinations for RAW checks.
module wb_regfile #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic              flush,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [ADDR_W:0]   pending_cnt
);

    logic [DATA_W-1:0]  regs_q [REG_NUM];
    logic [DATA_W-1:0]  regs_d [REG_NUM];
    logic [REG_NUM-1:0] pending_q, pending_d;
    logic [ADDR_W:0]    pending_cnt_q, pending_cnt_d;
    logic               commit;

    assign commit = wb_en && (wb_addr != '0);

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[wb_addr] = wb_data;
        end
    end

    // Set is applied after flush and clear so the newest producer always survives.
    always_comb begin
        pending_d = flush ? '0 : pending_q;
        if (commit) begin
            pending_d[wb_addr] = 1'b0;
        end
        if (issue_valid && (issue_dst != '0)) begin
            pending_d[issue_dst] = 1'b1;
        end
        pending_cnt_d = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            pending_cnt_d = pending_cnt_d + {{ADDR_W{1'b0}}, pending_d[i]};
        end
    end

    // NOTE: the register array is reset because software may read any register
    // before first writing it; that costs a reset net per flop, not a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
            pending_q     <= '0;
            pending_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value.
            regs_q        <= regs_d;
            pending_q     <= pending_d;
            pending_cnt_q <= pending_cnt_d;
        end
    end

    always_comb begin
        if (rs_addr == '0) begin
            rs_data = '0;
        end else if (wb_en && (wb_addr == rs_addr)) begin
            rs_data = wb_data;
        end else begin
            rs_data = regs_q[rs_addr];
        end
    end

    always_comb begin
        if (rt_addr == '0) begin
            rt_data = '0;
        end else if (wb_en && (wb_addr == rt_addr)) begin
            rt_data = wb_data;
        end else begin
            rt_data = regs_q[rt_addr];
        end
    end

    // A register committing this cycle is covered by the bypass, so it is not busy.
    assign rs_busy = pending_q[rs_addr] && !(wb_en && (wb_addr == rs_addr)) && (rs_addr != '0);
    assign rt_busy = pending_q[rt_addr] && !(wb_en && (wb_addr == rt_addr)) && (rt_addr != '0);

    assign pending_cnt = pending_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reference model plus a queue of expected
// post-edge pending counts, with directed test-plan cases and a random phase.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        issue_valid;
    logic [4:0]  issue_dst;
    logic        flush;
    logic        rs_busy;
    logic        rt_busy;
    logic [5:0]  pending_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl_regs [32];
    logic [31:0] mdl_pend;
    int          cnt_q [$];

    wb_regfile dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_en       (wb_en),
        .wb_data     (wb_data),
        .wb_addr     (wb_addr),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .issue_valid (issue_valid),
        .issue_dst   (issue_dst),
        .flush       (flush),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .pending_cnt (pending_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mdl_regs[a];
    endfunction

    function automatic logic mdl_busy(input logic [4:0] a);
        return mdl_pend[a] && !(wb_en && wb_addr == a) && (a != 5'd0);
    endfunction

    function automatic int popcount(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
        mdl_pend = 32'd0;
        cnt_q.delete();
    endtask

    // One pipeline cycle: drive on negedge, check the combinational view against
    // the model, queue the expected count, then compare it after the edge.
    task automatic cycle(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic iv, input logic [4:0] idst, input logic fl);
        logic [31:0] nxt_pend;
        @(negedge clk);
        wb_en = wen; wb_addr = waddr; wb_data = wdata;
        rs_addr = rs; rt_addr = rt;
        issue_valid = iv; issue_dst = idst; flush = fl;
        #1;
        check("rs_data", rs_data, mdl_read(rs));
        check("rt_data", rt_data, mdl_read(rt));
        check("rs_busy", {31'd0, rs_busy}, {31'd0, mdl_busy(rs)});
        check("rt_busy", {31'd0, rt_busy}, {31'd0, mdl_busy(rt)});
        nxt_pend = fl ? 32'd0 : mdl_pend;
        if (wen && waddr != 5'd0) nxt_pend[waddr] = 1'b0;
        if (iv && idst != 5'd0) nxt_pend[idst] = 1'b1;
        cnt_q.push_back(popcount(nxt_pend));
        @(posedge clk);
        if (wen && waddr != 5'd0) mdl_regs[waddr] = wdata;
        mdl_pend = nxt_pend;
        #1;
        if (cnt_q.size() == 0) begin
            check("cnt_queue_empty", 32'd1, 32'd0);
        end else begin
            check("pending_cnt", {26'd0, pending_cnt}, cnt_q.pop_front());
        end
    endtask

    // Mid-cycle read-only look at the outputs against fixed test-plan values.
    task automatic probe(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [31:0] exp_rs, input logic [31:0] exp_rt,
                         input logic exp_rsb, input logic exp_rtb, input int exp_cnt);
        wb_en = 1'b0; issue_valid = 1'b0; flush = 1'b0;
        rs_addr = rs; rt_addr = rt;
        #1;
        check({tag, ".rs_data"}, rs_data, exp_rs);
        check({tag, ".rt_data"}, rt_data, exp_rt);
        check({tag, ".rs_busy"}, {31'd0, rs_busy}, {31'd0, exp_rsb});
        check({tag, ".rt_busy"}, {31'd0, rt_busy}, {31'd0, exp_rtb});
        check({tag, ".cnt"}, {26'd0, pending_cnt}, exp_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        wb_en = 1'b0; wb_data = '0; wb_addr = '0;
        rs_addr = '0; rt_addr = '0;
        issue_valid = 1'b0; issue_dst = '0; flush = 1'b0;
        model_reset();
        #3;
        probe("reset", 5'd1, 5'd31, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write and readback, then writes to r0 are dropped.
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        probe("wr5", 5'd5, 5'd0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 0);
        cycle(1'b1, 5'd0, 32'h00001234, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        probe("wr0", 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0);

        // Bypass: in-cycle value comes from wb_data, stays after the edge.
        cycle(1'b1, 5'd3, 32'h00000011, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        cycle(1'b1, 5'd3, 32'h00000022, 5'd5, 5'd3, 1'b0, 5'd0, 1'b0);
        probe("bypass", 5'd5, 5'd3, 32'hDEADBEEF, 32'h00000022, 1'b0, 1'b0, 0);

        // Scoreboard set then clear through commit.
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0);
        probe("issue7", 5'd7, 5'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1);
        cycle(1'b1, 5'd7, 32'h0000ABCD, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        probe("commit7", 5'd7, 5'd0, 32'h0000ABCD, 32'd0, 1'b0, 1'b0, 0);

        // Same-cycle set and clear on one register: set wins.
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        cycle(1'b1, 5'd9, 32'h00000999, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0);
        probe("collide9", 5'd9, 5'd0, 32'h00000999, 32'd0, 1'b1, 1'b0, 1);
        cycle(1'b1, 5'd9, 32'h00000998, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        probe("issue0", 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);

        // Flush keeps only the same-cycle issue; late wb writes data only.
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd2, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
        cycle(1'b0, 5'd0, 32'd0, 5'd2, 5'd4, 1'b1, 5'd6, 1'b0);
        probe("pre_flush", 5'd2, 5'd6, 32'd0, 32'd0, 1'b1, 1'b1, 3);
        cycle(1'b0, 5'd0, 32'd0, 5'd4, 5'd8, 1'b1, 5'd8, 1'b1);
        probe("flush", 5'd8, 5'd4, 32'd0, 32'd0, 1'b1, 1'b0, 1);
        cycle(1'b1, 5'd4, 32'h00004444, 5'd4, 5'd8, 1'b0, 5'd0, 1'b0);
        probe("late_wb", 5'd4, 5'd8, 32'h00004444, 32'd0, 1'b0, 1'b1, 1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                  5'($urandom), 5'($urandom),
                  1'($urandom_range(0, 1)), 5'($urandom),
                  ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-cycle with work in flight.
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd12, 1'b0);
        cycle(1'b1, 5'd5, 32'h5555AAAA, 5'd0, 5'd0, 1'b1, 5'd13, 1'b0);
        @(negedge clk);
        wb_en = 1'b1; wb_addr = 5'd14; wb_data = 32'hFFFF0000;
        issue_valid = 1'b1; issue_dst = 5'd15;
        #2;
        rst_n = 1'b0;
        model_reset();
        probe("async_rst", 5'd5, 5'd12, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        probe("async_rst2", 5'd13, 5'd14, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 5'd0, 32'd0, 5'd14, 5'd15, 1'b0, 5'd0, 1'b0);
        probe("post_rst", 5'd14, 5'd15, 32'd0, 32'd0, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage plus architectural register file.
- Consumes the MEM/WB pipeline register outputs (write enable, result, destination address) and commits results to a 32-entry register file.
- Provides two combinational read ports with same-cycle write bypass to the decode stage.
- Keeps a per-register pending scoreboard so decode can detect RAW hazards on results still in flight.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- REG_NUM, 32, number of registers (2**ADDR_W).

Ports:
- clk  input  1  pipeline clock; register file and scoreboard update on posedge; upstream pipeline registers update on negedge.
- rst_n  input  1  asynchronous active-low reset.
- wb_en  input  1  write-back enable from MEM/WB wb output.
- wb_data  input  DATA_W  result from MEM/WB ALU_result output.
- wb_addr  input  ADDR_W  destination from MEM/WB dst_addr output.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data.
- rt_data  output  DATA_W  read port B data.
- issue_valid  input  1  decode issues an instruction that will write issue_dst.
- issue_dst  input  ADDR_W  destination of the issued instruction.
- flush  input  1  clears all pending bits (branch squash).
- rs_busy  output  1  rs_addr has an outstanding write not yet committed.
- rt_busy  output  1  same for rt_addr.
- pending_cnt  output  ADDR_W+1  number of set pending bits.

Behaviour:
- Reset (rst_n=0, async):
  - all registers = 0.
  - all pending bits = 0.
  - pending_cnt = 0.
  - rs_data, rt_data, rs_busy and rt_busy are then 0 because they are combinational from cleared state.
  - Reset asserted mid-operation discards every in-flight write and issue that cycle.
- Register 0:
  - Hardwired to 0; writes to it are ignored.
  - Its pending bit is never set.
  - Reads of it return 0 and busy=0.
- Write: on posedge clk, if wb_en && wb_addr!=0, reg[wb_addr] <= wb_data. Latency 1 edge.
- Read (combinational):
  - rs_data = 0 if rs_addr==0.
  - Otherwise, if wb_en && wb_addr==rs_addr, rs_data = wb_data (bypass).
  - Otherwise rs_data = reg[rs_addr].
  - rt_data: same rules using rt_addr.
- Scoreboard, on posedge clk:
  - Clear: if wb_en && wb_addr!=0, pending[wb_addr] <= 0.
  - Set: if issue_valid && issue_dst!=0, pending[issue_dst] <= 1.
  - Same register set and cleared in the same cycle: set wins (the newer producer stays outstanding).
  - flush=1: all pending bits <= 0, then the same-cycle issue set still applies. The issued instruction is the surviving one.
  - A late wb after a flush still writes the register normally; its clear is then a no-op.
- Busy (combinational):
  - rs_busy = pending[rs_addr] && !(wb_en && wb_addr==rs_addr) && rs_addr!=0. A register being committed this cycle is not busy because bypass covers it.
  - rt_busy: same rules using rt_addr.
- pending_cnt:
  - Registered popcount, updated on the same edge as the pending bits; always equals the popcount of the pending vector.
  - Range 0..31; cannot wrap.
- Single write port only; multiple issues to the same destination before commit collapse into one pending bit.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with pending bits set -> registers, pending_cnt and busy go to 0 immediately, without waiting for a clock edge.
- Write/readback: wb_en=1, wb_addr=5, wb_data=0xDEADBEEF; one edge later rs_addr=5 -> rs_data=0xDEADBEEF. With wb_en=1, addr 0, data 0x1234 -> rs_addr=0 reads 0.
- Bypass: reg3=0x11 and wb_en=1, wb_addr=3, wb_data=0x22 in the same cycle, rt_addr=3 -> rt_data=0x22 before the edge and 0x22 after it.
- Scoreboard: issue_valid, issue_dst=7 -> next cycle rs_busy=1 with rs_addr=7, pending_cnt=1. Then wb_en, wb_addr=7 -> rs_busy=0 in that cycle, pending_cnt=0 after the edge.
- Collision: pending[9]=1; in the same cycle wb_en with wb_addr=9 and issue_valid with issue_dst=9 -> after the edge pending[9]=1 and pending_cnt unchanged.
- Flush: pending on 2, 4 and 6; flush=1 with issue_dst=8 -> after the edge only pending[8]=1 and pending_cnt=1. A later wb to 4 writes data and pending_cnt stays 1.
